// File: rtl/pl_datamem_io.sv
// pl_datamem_io - MEM-stage data memory with a memory-mapped I/O window.
//
// Single clock, registered loads, byte-lane stores. addr[IO_BIT] splits the
// space: 0 -> internal word RAM (aliases above DEPTH_LOG2+1), 1 -> I/O window
// indexed by addr[IO_BIT-1:2]:
//   0 .. NUM_OUT-1            out registers (r/w)
//   NUM_OUT .. +NUM_IN-1      synchronised input ports (read-only)
//   NUM_OUT+NUM_IN            change-status register (read clears flags)
//   anything else             reads 0, writes ignored
//
// Ports:
//   clock, resetn          clock, async active-low reset
//   addr, datain, we, be   store request with byte-lane enables
//   re, dataout            load request, registered load data (1-cycle)
//   out_port               NUM_OUT flattened 32-bit output registers
//   in_port                NUM_IN flattened asynchronous input ports
//   in_changed             sticky per-port change flags

// Per-input-port lane: 2-flop synchroniser, change-detect register and the
// sticky change flag.
module pl_datamem_io_sync (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] d,
  input  logic        clr,
  output logic [31:0] q,
  output logic        flag
);
  logic [31:0] s1, s2, s3;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      flag <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      // a fresh change beats a status-read clear in the same cycle
      flag <= (s2 != s3) | (flag & ~clr);
    end
  end

  assign q = s2;
endmodule

module pl_datamem_io #(
  parameter int DEPTH_LOG2 = 5,
  parameter int NUM_OUT    = 4,
  parameter int NUM_IN     = 2,
  parameter int IO_BIT     = 7
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [31:0]           addr,
  input  logic [31:0]           datain,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic                  re,
  output logic [31:0]           dataout,
  output logic [32*NUM_OUT-1:0] out_port,
  input  logic [32*NUM_IN-1:0]  in_port,
  output logic [NUM_IN-1:0]     in_changed
);
  localparam int IW   = IO_BIT - 2;
  localparam int STAT = NUM_OUT + NUM_IN;

  logic [31:0]                mem [2**DEPTH_LOG2];
  logic [NUM_OUT-1:0][31:0]   out_q;
  logic [NUM_IN-1:0][31:0]    in_s2;
  logic [NUM_IN-1:0]          flag;

  logic                  is_io;
  logic [IW-1:0]         idx;
  logic [DEPTH_LOG2-1:0] ridx;
  logic                  stat_rd;
  logic [31:0]           rdata;

  assign is_io   = addr[IO_BIT];
  assign idx     = addr[IO_BIT-1:2];
  assign ridx    = addr[DEPTH_LOG2+1:2];
  assign stat_rd = re & is_io & (idx == IW'(STAT));

  logic unused_addr;
  assign unused_addr = ^{addr[31:IO_BIT+1], addr[1:0]};

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    pl_datamem_io_sync u_sync (
      .clock  (clock),
      .resetn (resetn),
      .d      (in_port[32*k +: 32]),
      .clr    (stat_rd),
      .q      (in_s2[k]),
      .flag   (flag[k])
    );
  end

  // RAM is deliberately not reset.
  always_ff @(posedge clock) begin
    if (we && !is_io)
      for (int n = 0; n < 4; n++)
        if (be[n]) mem[ridx][8*n +: 8] <= datain[8*n +: 8];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
    end else if (we && is_io) begin
      for (int k = 0; k < NUM_OUT; k++)
        if (idx == IW'(k))
          for (int n = 0; n < 4; n++)
            if (be[n]) out_q[k][8*n +: 8] <= datain[8*n +: 8];
    end
  end

  // Read mux sees pre-edge state, so a same-cycle store reads old data.
  always_comb begin
    rdata = '0;
    if (!is_io) begin
      rdata = mem[ridx];
    end else begin
      for (int k = 0; k < NUM_OUT; k++)
        if (idx == IW'(k)) rdata = out_q[k];
      for (int k = 0; k < NUM_IN; k++)
        if (idx == IW'(NUM_OUT + k)) rdata = in_s2[k];
      if (idx == IW'(STAT)) rdata = 32'(flag);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  dataout <= '0;
    else if (re)  dataout <= rdata;
  end

  assign out_port   = out_q;
  assign in_changed = flag;
endmodule
